// File: rtl/ss_readout_ctrl.sv
// Streams a status header, the shared-secret memory and an optional XOR checksum
// out to uart_sender one byte at a time, handshaking on uart_busy.
module ss_readout_ctrl #(
   parameter int NWORDS      = 8,
   parameter int ADDR_W      = 3,
   parameter int ACK_TIMEOUT = 4096,
   parameter bit LSB_FIRST   = 1'b1,
   parameter bit SEND_CSUM   = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [7:0]        status_byte,
   input  logic              abort,
   output logic              mem_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [63:0]       mem_q,
   output logic              send_en,
   output logic [7:0]        send_data,
   input  logic              uart_busy,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int ACK_W = $clog2(ACK_TIMEOUT) + 1;

   typedef enum logic [2:0] {
      S_IDLE, S_TX_ISSUE, S_TX_ACK, S_TX_DRAIN, S_FETCH, S_LATCH, S_DONE
   } state_t;

   typedef enum logic [1:0] {PH_HDR, PH_DATA, PH_CSUM} phase_t;

   state_t            r_state, w_state_nxt;
   phase_t            r_phase;
   logic [7:0]        r_hdr;
   logic [7:0]        r_csum;
   logic [7:0]        r_send_data;
   logic [63:0]       r_shift;
   logic [ADDR_W-1:0] r_word_idx;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [2:0]        r_byte_idx;
   logic [ACK_W-1:0]  r_ack_cnt;
   logic              r_send_en, r_done, r_err;

   logic [7:0]        w_cur_byte;
   logic              w_abort, w_issue, w_drain, w_timeout, w_last_word;
   logic              w_send_en, w_done, w_err;

   // Abort outranks every transition except in IDLE, where it is ignored.
   assign w_abort     = (r_state != S_IDLE) && abort;
   assign w_issue     = (r_state == S_TX_ISSUE) && !uart_busy && !w_abort;
   assign w_drain     = (r_state == S_TX_DRAIN) && !uart_busy && !w_abort;
   assign w_timeout   = (r_state == S_TX_ACK) && !uart_busy &&
                        (r_ack_cnt == ACK_W'(ACK_TIMEOUT - 1));
   assign w_last_word = (r_word_idx == ADDR_W'(NWORDS - 1));

   always_comb begin
      w_cur_byte = r_hdr;
      case (r_phase)
         PH_DATA: w_cur_byte = LSB_FIRST ? r_shift[7:0] : r_shift[63:56];
         PH_CSUM: w_cur_byte = r_csum;
         default: w_cur_byte = r_hdr;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_abort) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:     if (start) w_state_nxt = S_TX_ISSUE;
            S_TX_ISSUE: if (!uart_busy) w_state_nxt = S_TX_ACK;
            S_TX_ACK: begin
               if (uart_busy)      w_state_nxt = S_TX_DRAIN;
               else if (w_timeout) w_state_nxt = S_IDLE;
            end
            S_TX_DRAIN: begin
               if (!uart_busy) begin
                  case (r_phase)
                     PH_HDR:  w_state_nxt = S_FETCH;
                     PH_DATA: begin
                        if (r_byte_idx != 3'd7) w_state_nxt = S_TX_ISSUE;
                        else if (!w_last_word)  w_state_nxt = S_FETCH;
                        else if (SEND_CSUM)     w_state_nxt = S_TX_ISSUE;
                        else                    w_state_nxt = S_DONE;
                     end
                     default: w_state_nxt = S_DONE;
                  endcase
               end
            end
            S_FETCH:    w_state_nxt = S_LATCH;
            S_LATCH:    w_state_nxt = S_TX_ISSUE;
            S_DONE:     w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_comb begin
      w_send_en = w_issue;
      w_done    = (r_state == S_DONE) && !w_abort;
      w_err     = w_abort || w_timeout;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_phase     <= PH_HDR;
         r_hdr       <= '0;
         r_csum      <= '0;
         r_shift     <= '0;
         r_word_idx  <= '0;
         r_byte_idx  <= '0;
         r_ack_cnt   <= '0;
         r_mem_addr  <= '0;
         r_send_data <= '0;
         r_send_en   <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_send_en <= w_send_en;
         r_done    <= w_done;
         r_err     <= w_err;
         if ((r_state == S_IDLE) && start) begin
            r_hdr      <= status_byte;
            r_word_idx <= '0;
            r_byte_idx <= '0;
            r_csum     <= '0;
            r_phase    <= PH_HDR;
         end
         if (w_issue) begin
            r_send_data <= w_cur_byte;
            r_ack_cnt   <= '0;
            if (r_phase == PH_DATA) r_csum <= r_csum ^ w_cur_byte;
         end
         if ((r_state == S_TX_ACK) && !w_abort) r_ack_cnt <= r_ack_cnt + ACK_W'(1);
         if (w_drain) begin
            case (r_phase)
               PH_HDR: r_phase <= PH_DATA;
               PH_DATA: begin
                  if (r_byte_idx != 3'd7) begin
                     if (LSB_FIRST) r_shift <= {8'h00, r_shift[63:8]};
                     else           r_shift <= {r_shift[55:0], 8'h00};
                     r_byte_idx <= r_byte_idx + 3'd1;
                  end else if (!w_last_word) begin
                     r_word_idx <= r_word_idx + ADDR_W'(1);
                     r_byte_idx <= '0;
                  end else if (SEND_CSUM) begin
                     r_phase <= PH_CSUM;
                  end
               end
               default: ;
            endcase
         end
         if (r_state == S_FETCH) r_mem_addr <= r_word_idx;
         if ((r_state == S_LATCH) && !w_abort) r_shift <= mem_q;
      end
   end

   assign send_en   = r_send_en;
   assign send_data = r_send_data;
   assign done      = r_done;
   assign err       = r_err;
   assign busy      = (r_state != S_IDLE);
   assign mem_en    = (r_state == S_FETCH);
   assign mem_addr  = (r_state == S_FETCH) ? r_word_idx : r_mem_addr;

endmodule

// File: tb/tb_ss_readout_ctrl.sv
// Bench for ss_readout_ctrl: three parameter variants, each with its own memory
// and a 10-cycle-per-byte uart_sender busy model.
module tb_ss_readout_ctrl;

   localparam bit LSB_TAB  [3] = '{1'b1, 1'b0, 1'b0};
   localparam bit CSUM_TAB [3] = '{1'b1, 1'b1, 1'b0};

   logic        clk = 1'b0;
   logic        rst_n;
   logic        abort;
   logic [7:0]  status_byte;
   logic        start     [3];
   logic        mem_en    [3];
   logic [2:0]  mem_addr  [3];
   logic [63:0] mem_q     [3];
   logic        send_en   [3];
   logic [7:0]  send_data [3];
   logic        uart_busy [3];
   logic        busy      [3];
   logic        done      [3];
   logic        err       [3];

   logic [63:0] mem [3][8];
   int          ucnt [3] = '{0, 0, 0};
   bit          tie_low = 1'b0;

   int checks = 0;
   int errors = 0;

   logic [7:0] obs_q [$];
   logic [2:0] addr_q [$];
   int n_send, n_done, n_err, n_both, n_viol, n_memen;
   int first_send_cyc, last_send_cyc, done_cyc, err_cyc;
   bit ended;
   logic busy_end;

   always #5 clk = ~clk;

   ss_readout_ctrl #(.ACK_TIMEOUT(16)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start[0]), .status_byte(status_byte), .abort(abort),
      .mem_en(mem_en[0]), .mem_addr(mem_addr[0]), .mem_q(mem_q[0]), .send_en(send_en[0]),
      .send_data(send_data[0]), .uart_busy(uart_busy[0]), .busy(busy[0]), .done(done[0]), .err(err[0]));

   ss_readout_ctrl #(.ACK_TIMEOUT(16), .LSB_FIRST(1'b0)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start[1]), .status_byte(status_byte), .abort(abort),
      .mem_en(mem_en[1]), .mem_addr(mem_addr[1]), .mem_q(mem_q[1]), .send_en(send_en[1]),
      .send_data(send_data[1]), .uart_busy(uart_busy[1]), .busy(busy[1]), .done(done[1]), .err(err[1]));

   ss_readout_ctrl #(.ACK_TIMEOUT(16), .LSB_FIRST(1'b0), .SEND_CSUM(1'b0)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .start(start[2]), .status_byte(status_byte), .abort(abort),
      .mem_en(mem_en[2]), .mem_addr(mem_addr[2]), .mem_q(mem_q[2]), .send_en(send_en[2]),
      .send_data(send_data[2]), .uart_busy(uart_busy[2]), .busy(busy[2]), .done(done[2]), .err(err[2]));

   always_comb begin
      for (int i = 0; i < 3; i++) uart_busy[i] = (ucnt[i] != 0);
   end

   always @(posedge clk) begin
      for (int j = 0; j < 3; j++) begin
         if (!rst_n)                       ucnt[j] <= 0;
         else if (send_en[j] && !tie_low)  ucnt[j] <= 10;
         else if (ucnt[j] != 0)            ucnt[j] <= ucnt[j] - 1;
         if (mem_en[j]) mem_q[j] <= mem[j][mem_addr[j]];
      end
   end

   task automatic kick(input int sel, input logic [7:0] sb, input bit abt, output logic busy_seen);
      @(negedge clk);
      status_byte = sb;
      start[sel]  = 1'b1;
      abort       = abt;
      @(negedge clk);
      start[sel]  = 1'b0;
      abort       = 1'b0;
      status_byte = 8'h00;
      busy_seen   = busy[sel];
   endtask

   // Records one frame's activity until done/err or the cycle budget runs out.
   task automatic collect(input int sel, input int max_cyc, input int poke);
      obs_q.delete();
      addr_q.delete();
      n_send = 0; n_done = 0; n_err = 0; n_both = 0; n_viol = 0; n_memen = 0;
      first_send_cyc = -1; last_send_cyc = -1; done_cyc = -1; err_cyc = -1;
      ended = 1'b0; busy_end = 1'bx;
      for (int c = 1; c <= max_cyc; c++) begin
         @(negedge clk);
         start[sel] = 1'b0;
         if (send_en[sel]) begin
            if (first_send_cyc < 0) first_send_cyc = c;
            last_send_cyc = c;
            n_send++;
            obs_q.push_back(send_data[sel]);
            if (uart_busy[sel]) n_viol++;
         end
         if (mem_en[sel]) begin
            n_memen++;
            addr_q.push_back(mem_addr[sel]);
         end
         if (done[sel]) begin n_done++; done_cyc = c; end
         if (err[sel])  begin n_err++;  err_cyc  = c; end
         if (done[sel] && err[sel]) n_both++;
         if (done[sel] || err[sel]) begin
            ended = 1'b1;
            busy_end = busy[sel];
            break;
         end
         if (poke > 0 && (c % poke) == 0) start[sel] = 1'b1;
      end
      start[sel] = 1'b0;
   endtask

   task automatic test_reset();
      logic [15:0] v;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         v = {send_en[i], send_data[i], mem_en[i], mem_addr[i], busy[i], done[i], err[i]};
         checks++;
         if (v !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs dut%0d got %h want 0000", i, v);
         end
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_frame(input int sel, input int poke, input bit abt, input string nm);
      logic [7:0] exp_q [$];
      logic [7:0] cs, e, o;
      logic       bz;
      int         n;
      cs = 8'h00;
      exp_q.push_back(8'h59);
      for (int w = 0; w < 8; w++) begin
         for (int k = 0; k < 8; k++) begin
            e = LSB_TAB[sel] ? mem[sel][w][8*k +: 8] : mem[sel][w][63-8*k -: 8];
            exp_q.push_back(e);
            cs ^= e;
         end
      end
      if (CSUM_TAB[sel]) exp_q.push_back(cs);
      n = exp_q.size();
      kick(sel, 8'h59, abt, bz);
      checks++;
      if (bz !== 1'b1) begin errors++; $display("FAIL %s busy_after_start got %b want 1", nm, bz); end
      collect(sel, 4000, poke);
      checks++;
      if (!ended) begin errors++; $display("FAIL %s frame_end got none want done within budget", nm); end
      checks++;
      if (n_send != n) begin errors++; $display("FAIL %s byte_count got %0d want %0d", nm, n_send, n); end
      for (int i = 0; exp_q.size() > 0; i++) begin
         e = exp_q.pop_front();
         o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
         checks++;
         if (o !== e) begin errors++; $display("FAIL %s byte%0d got %h want %h", nm, i, o, e); end
      end
      checks++;
      if (n_done != 1 || n_err != 0 || n_both != 0) begin
         errors++;
         $display("FAIL %s pulses got done=%0d err=%0d both=%0d want 1/0/0", nm, n_done, n_err, n_both);
      end
      checks++;
      if (n_viol != 0) begin errors++; $display("FAIL %s send_while_busy got %0d want 0", nm, n_viol); end
      checks++;
      if (n_memen != 8) begin errors++; $display("FAIL %s mem_en_cycles got %0d want 8", nm, n_memen); end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (i >= addr_q.size()) begin
            errors++; $display("FAIL %s mem_addr%0d got none want %0d", nm, i, i);
         end else if (addr_q[i] !== 3'(i)) begin
            errors++; $display("FAIL %s mem_addr%0d got %0d want %0d", nm, i, addr_q[i], i);
         end
      end
      checks++;
      if (busy_end !== 1'b0) begin errors++; $display("FAIL %s busy_at_done got %b want 0", nm, busy_end); end
      checks++;
      if (done_cyc - last_send_cyc < 11 || done_cyc - last_send_cyc > 16) begin
         errors++;
         $display("FAIL %s done_after_drain got gap %0d want 11..16", nm, done_cyc - last_send_cyc);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_timeout();
      logic bz;
      tie_low = 1'b1;
      kick(0, 8'h59, 1'b0, bz);
      collect(0, 200, 0);
      checks++;
      if (n_send != 1 || obs_q.size() < 1 || obs_q[0] !== 8'h59) begin
         errors++; $display("FAIL timeout_sends got %0d want 1 header", n_send);
      end
      checks++;
      if (n_err != 1 || n_done != 0) begin
         errors++; $display("FAIL timeout_pulses got err=%0d done=%0d want 1/0", n_err, n_done);
      end
      checks++;
      if (err_cyc - first_send_cyc != 16) begin
         errors++; $display("FAIL timeout_delay got %0d want 16", err_cyc - first_send_cyc);
      end
      checks++;
      if (busy_end !== 1'b0 || n_memen != 0) begin
         errors++; $display("FAIL timeout_idle got busy=%b mem_en=%0d want 0/0", busy_end, n_memen);
      end
      tie_low = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_abort();
      logic bz;
      int   cnt;
      bit   hit;
      cnt = 0;
      hit = 1'b0;
      kick(0, 8'h59, 1'b0, bz);
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (send_en[0]) cnt++;
         if (cnt == 27) begin hit = 1'b1; break; end
      end
      checks++;
      if (!hit) begin errors++; $display("FAIL abort_reach27 got %0d sends want 27", cnt); end
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checks++;
      if (err[0] !== 1'b1 || send_en[0] !== 1'b0 || busy[0] !== 1'b0) begin
         errors++;
         $display("FAIL abort_response got err=%b send_en=%b busy=%b want 1/0/0", err[0], send_en[0], busy[0]);
      end
      @(negedge clk);
      checks++;
      if (err[0] !== 1'b0) begin errors++; $display("FAIL abort_err_pulse got %b want 0", err[0]); end
      repeat (12) @(negedge clk);
      test_frame(0, 0, 1'b1, "abort_restart");
   endtask

   task automatic test_reset_midframe();
      logic       bz;
      logic [7:0] v;
      int         cnt;
      cnt = 0;
      kick(0, 8'h59, 1'b0, bz);
      for (int c = 0; c < 1000 && cnt < 5; c++) begin
         @(negedge clk);
         if (send_en[0]) cnt++;
      end
      checks++;
      if (cnt < 5) begin errors++; $display("FAIL midreset_progress got %0d sends want 5", cnt); end
      rst_n = 1'b0;
      @(negedge clk);
      v = {send_en[0], mem_en[0], mem_addr[0], busy[0], done[0], err[0]};
      checks++;
      if (v !== 8'h00) begin errors++; $display("FAIL midreset_ctrl got %h want 00", v); end
      checks++;
      if (send_data[0] !== 8'h00) begin errors++; $display("FAIL midreset_data got %h want 00", send_data[0]); end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog got no finish want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      abort = 1'b0;
      status_byte = 8'h00;
      for (int i = 0; i < 3; i++) start[i] = 1'b0;
      for (int w = 0; w < 8; w++) begin
         for (int k = 0; k < 8; k++) mem[0][w][8*k +: 8] = 8'(8*w + k);
         mem[1][w] = 64'h0;
         mem[2][w] = 64'h0;
      end
      mem[1][0] = 64'h00000000000000FF;
      mem[2][0] = 64'h00000000000000FF;

      test_reset();
      test_frame(0, 0, 1'b0, "lsb_frame");
      test_frame(0, 7, 1'b0, "start_ignored");
      test_frame(1, 0, 1'b0, "msb_csum");
      test_frame(2, 0, 1'b0, "msb_nocsum");
      test_timeout();
      test_abort();
      test_reset_midframe();
      test_frame(0, 0, 1'b0, "after_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
